// File: rtl/lcd_pkg.sv
// Shared widths, command encoding and host-agent FSM state for the LCD host side.
package lcd_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned IMG_W  = 8;
    localparam int unsigned CMD_W  = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_WRITE   = 4'd0,
        SHIFT_UP    = 4'd1,
        SHIFT_DOWN  = 4'd2,
        SHIFT_LEFT  = 4'd3,
        SHIFT_RIGHT = 4'd4,
        MAX         = 4'd5,
        MIN         = 4'd6,
        AVG         = 4'd7,
        ROT_CCW     = 4'd8,
        ROT_CW      = 4'd9,
        MIRROR_X    = 4'd10,
        MIRROR_Y    = 4'd11
    } lcd_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_BUSY
    } agent_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command FIFO; a push while full is accepted only if a pop frees a slot in the same cycle.
module lcd_cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign ovf     = push && full && !pop_ok;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lcd_host_agent.sv
// Host agent: serves the source image, issues queued commands under the busy
// handshake, captures result writes and keeps sticky status flags.
module lcd_host_agent
    import lcd_pkg::*;
#(
    parameter int unsigned QDEPTH      = 8,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              img_we,
    input  logic [ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0] img_wdata,
    input  logic              q_push,
    input  logic [CMD_W-1:0]  q_cmd,
    output logic              q_full,
    output logic              q_empty,
    input  logic              clr,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_valid,
    input  logic              busy,
    input  logic              IROM_rd,
    input  logic [ADDR_W-1:0] IROM_A,
    output logic [DATA_W-1:0] IROM_Q,
    input  logic              IRAM_valid,
    input  logic [ADDR_W-1:0] IRAM_A,
    input  logic [DATA_W-1:0] IRAM_D,
    input  logic              done,
    input  logic [ADDR_W-1:0] cap_addr,
    output logic [DATA_W-1:0] cap_data,
    output logic [6:0]        wr_count,
    output logic              done_seen,
    output logic              err_ack,
    output logic              err_ovf
);

    localparam int unsigned TW     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [6:0]  WR_MAX = 7'(IMG_W * IMG_W);

    logic [DATA_W-1:0] img [IMG_W*IMG_W];
    logic [DATA_W-1:0] cap [IMG_W*IMG_W];

    agent_state_e     state, state_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [CMD_W-1:0] cmd_nx, q_head;
    logic             cmd_valid_nx;
    logic             q_pop, q_ovf;
    logic             can_issue, ack_expired;

    lcd_cmd_fifo #(.DEPTH(QDEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .din   (q_cmd),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .ovf   (q_ovf)
    );

    always_ff @(posedge clk) begin
        if (img_we)     img[img_addr] <= img_wdata;
        if (IRAM_valid) cap[IRAM_A]   <= IRAM_D;
    end

    assign cap_data = cap[cap_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       IROM_Q <= '0;
        else if (IROM_rd) IROM_Q <= img[IROM_A];
    end

    // Set events take priority over clr so a same-cycle done or write is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count  <= '0;
            done_seen <= 1'b0;
            err_ack   <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            if (clr)
                wr_count <= IRAM_valid ? 7'd1 : 7'd0;
            else if (IRAM_valid && wr_count != WR_MAX)
                wr_count <= wr_count + 1'b1;
            done_seen <= done        | (done_seen & ~clr);
            err_ack   <= ack_expired | (err_ack   & ~clr);
            err_ovf   <= q_ovf       | (err_ovf   & ~clr);
        end
    end

    assign can_issue   = !q_empty && !busy && !done_seen;
    assign ack_expired = (state == ST_WAIT_ACK) && !busy && (timer == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            cmd       <= cmd_nx;
            cmd_valid <= cmd_valid_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (can_issue) state_nx = ST_ISSUE;
            ST_ISSUE:     state_nx = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (busy) state_nx = ST_WAIT_BUSY;
                          else if (ack_expired) state_nx = ST_IDLE;
            ST_WAIT_BUSY: if (!busy) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        q_pop        = (state == ST_IDLE) && can_issue;
        cmd_nx       = q_pop ? q_head : cmd;
        cmd_valid_nx = q_pop;
        timer_nx     = (state == ST_WAIT_ACK && !busy) ? timer + 1'b1 : '0;
    end

endmodule

// File: tb/tb_lcd_host_agent.sv
// Directed self-checking bench for lcd_host_agent; the bench plays the controller side.
module tb_lcd_host_agent;

    logic       clk = 1'b0;
    logic       reset;
    logic       img_we;
    logic [5:0] img_addr;
    logic [7:0] img_wdata;
    logic       q_push;
    logic [3:0] q_cmd;
    logic       q_full, q_empty;
    logic       clr;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;
    logic       done;
    logic [5:0] cap_addr;
    logic [7:0] cap_data;
    logic [6:0] wr_count;
    logic       done_seen, err_ack, err_ovf;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int waited;
    int t_prev;

    lcd_host_agent #(.QDEPTH(8), .ACK_TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .img_we     (img_we),
        .img_addr   (img_addr),
        .img_wdata  (img_wdata),
        .q_push     (q_push),
        .q_cmd      (q_cmd),
        .q_full     (q_full),
        .q_empty    (q_empty),
        .clr        (clr),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .IROM_rd    (IROM_rd),
        .IROM_A     (IROM_A),
        .IROM_Q     (IROM_Q),
        .IRAM_valid (IRAM_valid),
        .IRAM_A     (IRAM_A),
        .IRAM_D     (IRAM_D),
        .done       (done),
        .cap_addr   (cap_addr),
        .cap_data   (cap_data),
        .wr_count   (wr_count),
        .done_seen  (done_seen),
        .err_ack    (err_ack),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next strobe and check the command it carries.
    task automatic wait_pulse(input string tag, input logic [3:0] exp_cmd, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (cmd_valid !== 1'b1 && n < 12);
        chk({tag, "_valid"}, {31'd0, cmd_valid}, 32'd1);
        chk({tag, "_cmd"}, {28'd0, cmd}, {28'd0, exp_cmd});
    endtask

    // Controller acknowledges a strobe: busy for two cycles, then releases.
    task automatic respond();
        busy = 1'b1;
        tick();
        tick();
        busy = 1'b0;
    endtask

    initial begin
        reset = 1'b0; img_we = 1'b0; img_addr = '0; img_wdata = '0;
        q_push = 1'b0; q_cmd = '0; clr = 1'b0; busy = 1'b0;
        IROM_rd = 1'b0; IROM_A = '0; IRAM_valid = 1'b0; IRAM_A = '0; IRAM_D = '0;
        done = 1'b0; cap_addr = '0;

        tick(); tick();
        chk("rst_cmd", {28'd0, cmd}, 32'd0);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_irom_q", {24'd0, IROM_Q}, 32'd0);
        chk("rst_q_empty", {31'd0, q_empty}, 32'd1);
        chk("rst_q_full", {31'd0, q_full}, 32'd0);
        chk("rst_wr_count", {25'd0, wr_count}, 32'd0);
        chk("rst_flags", {29'd0, done_seen, err_ack, err_ovf}, 32'd0);
        reset = 1'b1;
        tick();

        // Source image img[a] = a*3
        for (int a = 0; a < 64; a++) begin
            img_we = 1'b1; img_addr = 6'(a); img_wdata = 8'(a * 3);
            tick();
        end
        img_we = 1'b0;

        IROM_rd = 1'b1; IROM_A = 6'd5;
        tick();
        chk("irom_read5", {24'd0, IROM_Q}, 32'd15);
        IROM_rd = 1'b0; IROM_A = 6'd6;
        tick();
        chk("irom_hold", {24'd0, IROM_Q}, 32'd15);
        IROM_rd = 1'b1; IROM_A = 6'd7; img_we = 1'b1; img_addr = 6'd7; img_wdata = 8'hAA;
        tick();
        chk("irom_rw_old", {24'd0, IROM_Q}, 32'd21);
        img_we = 1'b0;
        tick();
        chk("irom_rw_new", {24'd0, IROM_Q}, 32'hAA);
        IROM_rd = 1'b0;

        // Issue gated by busy
        busy = 1'b1; q_push = 1'b1; q_cmd = 4'd4;
        tick();
        q_push = 1'b0;
        chk("busy_q_nonempty", {31'd0, q_empty}, 32'd0);
        tick(); tick(); tick();
        chk("busy_no_issue", {31'd0, cmd_valid}, 32'd0);
        busy = 1'b0;
        wait_pulse("first_issue", 4'd4, waited);
        chk("first_issue_lat", waited, 32'd1);
        respond();
        chk("first_pulse_drop", {31'd0, cmd_valid}, 32'd0);
        tick(); tick();
        chk("first_no_second", {31'd0, cmd_valid}, 32'd0);
        chk("first_q_empty", {31'd0, q_empty}, 32'd1);

        // Three commands in order, minimum spacing
        busy = 1'b1;
        q_push = 1'b1; q_cmd = 4'd4; tick();
        q_cmd = 4'd7; tick();
        q_cmd = 4'd0; tick();
        q_push = 1'b0; busy = 1'b0;
        wait_pulse("seq_a", 4'd4, waited);
        t_prev = cyc;
        respond();
        wait_pulse("seq_b", 4'd7, waited);
        chk("seq_gap_ab", cyc - t_prev, 32'd4);
        t_prev = cyc;
        respond();
        wait_pulse("seq_c", 4'd0, waited);
        chk("seq_gap_bc", cyc - t_prev, 32'd4);
        respond();
        tick(); tick();
        chk("seq_q_empty", {31'd0, q_empty}, 32'd1);
        chk("seq_idle", {31'd0, cmd_valid}, 32'd0);

        // Ack timeout, then next queued command still issues
        busy = 1'b1;
        q_push = 1'b1; q_cmd = 4'd11; tick();
        q_cmd = 4'd2; tick();
        q_push = 1'b0; busy = 1'b0;
        wait_pulse("to_issue", 4'd11, waited);
        tick();
        chk("to_enter_wait", {31'd0, err_ack}, 32'd0);
        tick(); tick(); tick();
        chk("to_not_yet", {31'd0, err_ack}, 32'd0);
        tick();
        chk("to_err_ack", {31'd0, err_ack}, 32'd1);
        tick();
        chk("to_next_valid", {31'd0, cmd_valid}, 32'd1);
        chk("to_next_cmd", {28'd0, cmd}, 32'd2);
        respond();
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        chk("to_clr", {31'd0, err_ack}, 32'd0);

        // Overflow: 8 fill, 9th dropped, push coincident with pop accepted
        busy = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            q_push = 1'b1; q_cmd = 4'(c);
            tick();
        end
        chk("ovf_full", {31'd0, q_full}, 32'd1);
        chk("ovf_not_yet", {31'd0, err_ovf}, 32'd0);
        q_cmd = 4'd9;
        tick();
        chk("ovf_flag", {31'd0, err_ovf}, 32'd1);
        busy = 1'b0; q_cmd = 4'd10;
        tick();
        q_push = 1'b0;
        chk("ovf_pop_valid", {31'd0, cmd_valid}, 32'd1);
        chk("ovf_pop_cmd", {28'd0, cmd}, 32'd1);
        chk("ovf_still_full", {31'd0, q_full}, 32'd1);
        for (int c = 2; c <= 9; c++) begin
            respond();
            wait_pulse("ovf_drain", (c == 9) ? 4'd10 : 4'(c), waited);
        end
        respond();
        tick();
        chk("ovf_drained", {31'd0, q_empty}, 32'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovf_clr", {31'd0, err_ovf}, 32'd0);

        // Capture buffer, saturation, done blocking
        for (int a = 0; a < 64; a++) begin
            IRAM_valid = 1'b1; IRAM_A = 6'(a); IRAM_D = 8'(63 - a);
            tick();
        end
        chk("cap_count64", {25'd0, wr_count}, 32'd64);
        IRAM_A = 6'd0; IRAM_D = 8'd63;
        tick();
        IRAM_valid = 1'b0;
        chk("cap_saturate", {25'd0, wr_count}, 32'd64);
        cap_addr = 6'd10; #1;
        chk("cap_addr10", {24'd0, cap_data}, 32'd53);
        cap_addr = 6'd63; #1;
        chk("cap_addr63", {24'd0, cap_data}, 32'd0);
        IRAM_valid = 1'b1; IRAM_A = 6'd5; IRAM_D = 8'hEE;
        tick();
        IRAM_valid = 1'b0; cap_addr = 6'd5; #1;
        chk("cap_overwrite", {24'd0, cap_data}, 32'hEE);
        done = 1'b1; tick(); done = 1'b0;
        chk("done_seen", {31'd0, done_seen}, 32'd1);
        q_push = 1'b1; q_cmd = 4'd3; tick(); q_push = 1'b0;
        tick(); tick(); tick();
        chk("done_block", {31'd0, cmd_valid}, 32'd0);
        chk("done_q_kept", {31'd0, q_empty}, 32'd0);
        clr = 1'b1; done = 1'b1; IRAM_valid = 1'b1; IRAM_A = 6'd0; IRAM_D = 8'd63;
        tick();
        clr = 1'b0; done = 1'b0; IRAM_valid = 1'b0;
        chk("clr_done_wins", {31'd0, done_seen}, 32'd1);
        chk("clr_wr_one", {25'd0, wr_count}, 32'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_done", {31'd0, done_seen}, 32'd0);
        chk("clr_wr_zero", {25'd0, wr_count}, 32'd0);
        chk("clr_no_issue_yet", {31'd0, cmd_valid}, 32'd0);
        wait_pulse("clr_release", 4'd3, waited);
        chk("clr_release_lat", waited, 32'd1);
        respond();
        tick();

        // Reset mid-handshake
        q_push = 1'b1; q_cmd = 4'd6; tick();
        q_cmd = 4'd8; tick();
        q_push = 1'b0;
        chk("mid_valid", {31'd0, cmd_valid}, 32'd1);
        chk("mid_cmd", {28'd0, cmd}, 32'd6);
        reset = 1'b0; #1;
        chk("mid_rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("mid_rst_flush", {31'd0, q_empty}, 32'd1);
        chk("mid_rst_cmd", {28'd0, cmd}, 32'd0);
        tick();
        reset = 1'b1;
        tick(); tick();
        chk("post_rst_idle", {31'd0, cmd_valid}, 32'd0);
        IROM_rd = 1'b1; IROM_A = 6'd5;
        tick();
        IROM_rd = 1'b0;
        chk("post_rst_img", {24'd0, IROM_Q}, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
